mc_ctrl: RTL and testbench

Main control FSM for the multicycle MIPS datapath instantiated under top. It decodes the 6-bit opcode latched in the instruction register. It sequences the fetch, decode, execute, memory and writeback steps by driving every datapath mux select and write enable. It also handshakes with the unified instruction/data memory and counts retired instructions for the bench.

---
 rtl/mc_pkg.sv | 51 +++++
 rtl/mc_ctrl.sv | 153 +++++++++++++++
 tb/tb_mc_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, FSM states
// and the datapath mux-select codes used by the controller, ALU control and datapath.
package mc_pkg;

   localparam int unsigned OP_W    = 6;
   localparam int unsigned STATE_W = 4;
   localparam int unsigned SEL_W   = 2;

   localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
   localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
   localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
   localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
   localparam logic [OP_W-1:0] OP_J     = 6'b000010;

   typedef enum logic [STATE_W-1:0] {
      ST_INIT   = 4'd0,
      ST_FETCH  = 4'd1,
      ST_DECODE = 4'd2,
      ST_MEMADR = 4'd3,
      ST_MEMRD  = 4'd4,
      ST_MEMWB  = 4'd5,
      ST_MEMWR  = 4'd6,
      ST_EXEC   = 4'd7,
      ST_RWB    = 4'd8,
      ST_BEQ    = 4'd9,
      ST_ADDIEX = 4'd10,
      ST_ADDIWB = 4'd11,
      ST_JUMP   = 4'd12
   } state_t;

   localparam logic [SEL_W-1:0] SRCB_REGB    = 2'b00;
   localparam logic [SEL_W-1:0] SRCB_FOUR    = 2'b01;
   localparam logic [SEL_W-1:0] SRCB_IMM     = 2'b10;
   localparam logic [SEL_W-1:0] SRCB_IMM_SH2 = 2'b11;

   localparam logic [SEL_W-1:0] ALUOP_ADD    = 2'b00;
   localparam logic [SEL_W-1:0] ALUOP_SUB    = 2'b01;
   localparam logic [SEL_W-1:0] ALUOP_FUNCT  = 2'b10;

   localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'b00;
   localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'b10;

   // True for every opcode the controller knows how to sequence.
   function automatic logic is_known_op(input logic [OP_W-1:0] op);
      return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
             (op == OP_BEQ)   || (op == OP_ADDI) || (op == OP_J);
   endfunction

endpackage

// File: rtl/mc_ctrl.sv
// Main control FSM of the multicycle MIPS datapath: sequences fetch/decode/
// execute/memory/writeback, handshakes with memory and counts retired instructions.
module mc_ctrl
   import mc_pkg::*;
#(
   parameter int unsigned CNT_W = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [OP_W-1:0]    opcode,
   input  logic               mem_ready,
   output logic               pc_write,
   output logic               pc_write_cond,
   output logic               iord,
   output logic               mem_read,
   output logic               mem_write,
   output logic               ir_write,
   output logic               mem_to_reg,
   output logic               reg_dst,
   output logic               reg_write,
   output logic               alu_src_a,
   output logic [SEL_W-1:0]   alu_src_b,
   output logic [SEL_W-1:0]   alu_op,
   output logic [SEL_W-1:0]   pc_source,
   output logic               illegal_op,
   output logic [STATE_W-1:0] state_dbg,
   output logic [CNT_W-1:0]   instr_cnt
);

   state_t           r_state;
   state_t           w_next;
   logic             w_retire;
   logic [CNT_W-1:0] r_cnt;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_INIT;
      else        r_state <= w_next;
   end

   // Next state and retire detection
   always_comb begin
      w_next   = ST_FETCH;
      w_retire = 1'b0;
      case (r_state)
         ST_INIT:   w_next = ST_FETCH;
         ST_FETCH:  w_next = mem_ready ? ST_DECODE : ST_FETCH;
         ST_DECODE: begin
            case (opcode)
               OP_LW, OP_SW: w_next = ST_MEMADR;
               OP_RTYPE:     w_next = ST_EXEC;
               OP_BEQ:       w_next = ST_BEQ;
               OP_ADDI:      w_next = ST_ADDIEX;
               OP_J:         w_next = ST_JUMP;
               default:      w_next = ST_FETCH;
            endcase
         end
         ST_MEMADR: w_next = (opcode == OP_LW) ? ST_MEMRD : ST_MEMWR;
         ST_MEMRD:  w_next = mem_ready ? ST_MEMWB : ST_MEMRD;
         ST_MEMWB: begin
            w_next   = ST_FETCH;
            w_retire = 1'b1;
         end
         ST_MEMWR: begin
            w_next   = mem_ready ? ST_FETCH : ST_MEMWR;
            w_retire = mem_ready;
         end
         ST_EXEC:   w_next = ST_RWB;
         ST_RWB, ST_BEQ, ST_ADDIWB, ST_JUMP: begin
            w_next   = ST_FETCH;
            w_retire = 1'b1;
         end
         ST_ADDIEX: w_next = ST_ADDIWB;
         default:   w_next = ST_FETCH;
      endcase
   end

   // Output decode; only FETCH strobes depend on mem_ready
   always_comb begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = SRCB_REGB;
      alu_op        = ALUOP_ADD;
      pc_source     = PCSRC_ALU;
      illegal_op    = 1'b0;
      case (r_state)
         ST_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = SRCB_FOUR;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
         end
         ST_DECODE: begin
            alu_src_b  = SRCB_IMM_SH2;
            illegal_op = !is_known_op(opcode);
         end
         ST_MEMADR, ST_ADDIEX: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
         end
         ST_MEMRD: begin
            mem_read = 1'b1;
            iord     = 1'b1;
         end
         ST_MEMWB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         ST_MEMWR: begin
            mem_write = 1'b1;
            iord      = 1'b1;
         end
         ST_EXEC: begin
            alu_src_a = 1'b1;
            alu_op    = ALUOP_FUNCT;
         end
         ST_RWB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
         end
         ST_BEQ: begin
            alu_src_a     = 1'b1;
            alu_op        = ALUOP_SUB;
            pc_write_cond = 1'b1;
            pc_source     = PCSRC_ALUOUT;
         end
         ST_ADDIWB: reg_write = 1'b1;
         ST_JUMP: begin
            pc_write  = 1'b1;
            pc_source = PCSRC_JUMP;
         end
         default: ;
      endcase
   end

   // Retired-instruction counter, wraps naturally
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        r_cnt <= '0;
      else if (w_retire) r_cnt <= r_cnt + CNT_W'(1);
   end

   assign state_dbg = r_state;
   assign instr_cnt = r_cnt;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: a per-cycle vector table for the instruction
// mix plus hand-written reset sequences.
module tb_mc_ctrl;

   localparam int unsigned CNT_W = 32;
   localparam int unsigned NV    = 36;

   logic             clk;
   logic             rst_n;
   logic [5:0]       opcode;
   logic             mem_ready;
   logic             pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
   logic             mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
   logic [1:0]       alu_src_b, alu_op, pc_source;
   logic [3:0]       state_dbg;
   logic [CNT_W-1:0] instr_cnt;

   mc_ctrl #(.CNT_W(CNT_W)) u_dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
      .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
      .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .pc_source(pc_source), .illegal_op(illegal_op), .state_dbg(state_dbg),
      .instr_cnt(instr_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [5:0]  op;
      logic        rdy;
      logic [3:0]  st;
      logic [16:0] outs;
      logic [31:0] cnt;
   } vec_t;

   vec_t vecs [NV];
   int   n_pass;
   int   n_total;

   localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
   localparam logic [5:0] BQ = 6'b000100, AI = 6'b001000, JP = 6'b000010;
   localparam logic [5:0] BAD = 6'b111111;

   function automatic logic [16:0] mk(input logic pcw, pwc, io, mr, mw, irw, m2r,
                                      rd, rw, sa, input logic [1:0] sb, ao, ps,
                                      input logic ill);
      return {pcw, pwc, io, mr, mw, irw, m2r, rd, rw, sa, sb, ao, ps, ill};
   endfunction

   function automatic logic [16:0] outs_now();
      return {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
              mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
              pc_source, illegal_op};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   task automatic setv(input int i, input logic [5:0] op, input logic rdy,
                       input logic [3:0] st, input logic [16:0] o, input logic [31:0] c);
      vecs[i].op = op; vecs[i].rdy = rdy; vecs[i].st = st; vecs[i].outs = o; vecs[i].cnt = c;
   endtask

   logic [16:0] e_init, e_f0, e_f1, e_dec, e_ill, e_madr, e_mrd, e_mwb, e_mwr;
   logic [16:0] e_exec, e_rwb, e_beq, e_aex, e_awb, e_jmp;

   initial begin
      n_pass = 0; n_total = 0;
      //            pcw pwc io mr mw irw m2r rd rw sa  sb     ao     ps    ill
      e_init = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
      e_f0   = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0);
      e_f1   = mk(1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0);
      e_dec  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0);
      e_ill  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 1);
      e_madr = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0);
      e_mrd  = mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
      e_mwb  = mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0);
      e_mwr  = mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
      e_exec = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 2'b00, 0);
      e_rwb  = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0);
      e_beq  = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01, 0);
      e_aex  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0);
      e_awb  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0);
      e_jmp  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 0);

      // Cycle-by-cycle table starting at the INIT cycle after reset release
      setv( 0, LW,  1, 0,  e_init, 0);
      setv( 1, LW,  1, 1,  e_f1,   0);
      setv( 2, LW,  1, 2,  e_dec,  0);
      setv( 3, LW,  1, 3,  e_madr, 0);
      setv( 4, LW,  1, 4,  e_mrd,  0);
      setv( 5, LW,  1, 5,  e_mwb,  0);
      setv( 6, SW,  1, 1,  e_f1,   1);
      setv( 7, SW,  1, 2,  e_dec,  1);
      setv( 8, SW,  1, 3,  e_madr, 1);
      setv( 9, SW,  0, 6,  e_mwr,  1);
      setv(10, SW,  0, 6,  e_mwr,  1);
      setv(11, SW,  0, 6,  e_mwr,  1);
      setv(12, SW,  1, 6,  e_mwr,  1);
      setv(13, RT,  0, 1,  e_f0,   2);
      setv(14, RT,  0, 1,  e_f0,   2);
      setv(15, RT,  1, 1,  e_f1,   2);
      setv(16, RT,  1, 2,  e_dec,  2);
      setv(17, RT,  1, 7,  e_exec, 2);
      setv(18, RT,  1, 8,  e_rwb,  2);
      setv(19, BQ,  1, 1,  e_f1,   3);
      setv(20, BQ,  1, 2,  e_dec,  3);
      setv(21, BQ,  1, 9,  e_beq,  3);
      setv(22, JP,  1, 1,  e_f1,   4);
      setv(23, JP,  1, 2,  e_dec,  4);
      setv(24, JP,  1, 12, e_jmp,  4);
      setv(25, AI,  1, 1,  e_f1,   5);
      setv(26, AI,  1, 2,  e_dec,  5);
      setv(27, AI,  1, 10, e_aex,  5);
      setv(28, AI,  1, 11, e_awb,  5);
      setv(29, BAD, 1, 1,  e_f1,   6);
      setv(30, BAD, 1, 2,  e_ill,  6);
      setv(31, LW,  1, 1,  e_f1,   6);
      setv(32, LW,  1, 2,  e_dec,  6);
      setv(33, LW,  0, 3,  e_madr, 6);
      setv(34, LW,  0, 4,  e_mrd,  6);
      setv(35, LW,  0, 4,  e_mrd,  6);

      // Reset held with inputs that would otherwise raise strobes
      rst_n = 1'b0; opcode = LW; mem_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check($sformatf("rst_state[%0d]", i), 32'(state_dbg), 32'd0);
         check($sformatf("rst_outs[%0d]", i), 32'(outs_now()), 32'd0);
      end
      check("rst_cnt", instr_cnt, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      for (int i = 0; i < NV; i++) begin
         opcode = vecs[i].op; mem_ready = vecs[i].rdy;
         @(negedge clk);
         check($sformatf("v%0d_state", i), 32'(state_dbg), 32'(vecs[i].st));
         check($sformatf("v%0d_outs", i), 32'(outs_now()), 32'(vecs[i].outs));
         check($sformatf("v%0d_cnt", i), instr_cnt, vecs[i].cnt);
         @(posedge clk); #1;
      end

      // Asynchronous reset while stalled in MEMRD
      mem_ready = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_state", 32'(state_dbg), 32'd0);
      check("async_rst_mem_read", 32'(mem_read), 32'd0);
      check("async_rst_iord", 32'(iord), 32'd0);
      check("async_rst_cnt", instr_cnt, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("rerun_init_state", 32'(state_dbg), 32'd0);
      check("rerun_init_outs", 32'(outs_now()), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      check("rerun_fetch_state", 32'(state_dbg), 32'd1);
      check("rerun_fetch_stall_outs", 32'(outs_now()), 32'(e_f0));
      check("rerun_cnt", instr_cnt, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
